// File: rtl/uart_host_tx.sv
// uart_host_tx: byte-stream UART transmitter with a small input FIFO.
// Bytes written on tx_wr are queued and then sent LSB first with a start bit,
// an optional parity bit and one or two stop bits. Frames follow each other
// with no idle gap while the FIFO holds data.
module uart_host_tx #(
  parameter int SYS_CLK_FREQ    = 100000000,
  parameter int BAUD_RATE       = 115200,
  parameter int DATA_BITS       = 8,
  parameter int STOP_BITS       = 1,
  parameter int PARITY_MODE     = 0,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic       tx_out,
  output logic       busy
);

  localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW           = FIFO_DEPTH_LOG2;
  localparam int DEPTH        = 1 << FIFO_DEPTH_LOG2;
  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]  fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          push;
  logic          pop;
  logic          fifo_nempty;
  logic [7:0]    head_payload;
  logic          head_parity;

  // Transmit FSM state
  state_t            state_reg, state_next;
  logic [BAUD_W-1:0] baud_reg, baud_next;
  logic [2:0]        bit_reg, bit_next;
  logic [7:0]        shift_reg, shift_next;
  logic              parity_reg, parity_next;
  logic              tx_reg, tx_next;
  logic              baud_tick;

  // A write is dropped whenever the registered occupancy says full,
  // regardless of a pop at the same edge.
  assign tx_full      = (count_reg == (PW+1)'(DEPTH));
  assign push         = tx_wr & ~tx_full;
  assign fifo_nempty  = (count_reg != '0);
  assign head_payload = fifo_mem[rd_ptr_reg] & DATA_MASK;
  assign head_parity  = (PARITY_MODE == 1) ? ~^head_payload : ^head_payload;
  assign baud_tick    = (baud_reg == BAUD_W'(CLKS_PER_BIT - 1));

  assign tx_out = tx_reg;
  assign busy   = (state_reg != IDLE) | fifo_nempty;

  // FIFO data array: written on accepted pushes, no reset needed
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop cancel out
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FSM and datapath registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg  <= IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      tx_reg     <= 1'b1;
    end else begin
      state_reg  <= state_next;
      baud_reg   <= baud_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      tx_reg     <= tx_next;
    end
  end

  // Next-state logic: the baud counter restarts on every bit or state change
  always_comb begin
    state_next  = state_reg;
    baud_next   = baud_reg + BAUD_W'(1);
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    tx_next     = tx_reg;
    pop         = 1'b0;

    case (state_reg)
      IDLE: begin
        baud_next = '0;
        tx_next   = 1'b1;
        if (fifo_nempty) begin
          pop         = 1'b1;
          shift_next  = head_payload;
          parity_next = head_parity;
          bit_next    = '0;
          state_next  = START;
          tx_next     = 1'b0;
        end
      end
      START: begin
        if (baud_tick) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
          tx_next    = shift_reg[0];
        end
      end
      DATA: begin
        if (baud_tick) begin
          baud_next = '0;
          if (bit_reg == 3'(DATA_BITS - 1)) begin
            bit_next = '0;
            if (PARITY_MODE != 0) begin
              state_next = PARITY;
              tx_next    = parity_reg;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_next   = bit_reg + 3'd1;
            shift_next = shift_reg >> 1;
            tx_next    = shift_reg[1];
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
      STOP: begin
        if (baud_tick) begin
          baud_next = '0;
          if (bit_reg == 3'(STOP_BITS - 1)) begin
            bit_next = '0;
            if (fifo_nempty) begin
              // Back-to-back: start the next frame on this very edge
              pop         = 1'b1;
              shift_next  = head_payload;
              parity_next = head_parity;
              state_next  = START;
              tx_next     = 1'b0;
            end else begin
              state_next = IDLE;
              tx_next    = 1'b1;
            end
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule
